// File: rtl/wb_slave_mux.sv
// Registered 1-master-to-N-slave Wishbone interconnect with address decode,
// slave error forwarding and hung-slave timeout.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   wbm_*                     master side (cyc/stb/we/sel/adr/dat in; dat/ack/err out)
//   wbs_cyc_o, wbs_stb_o      per-slave one-hot cycle/strobe
//   wbs_we/sel/adr/dat_o      broadcast request fields
//   wbs_dat/ack/err_i         per-slave responses, slave i data at [32i+31:32i]
module wb_slave_mux #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter int          NUM_SLAVES = 4,
  parameter int          SLAVE_AW   = 16,
  parameter int          TIMEOUT    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_we_i,
  input  logic [3:0]               wbm_sel_i,
  input  logic [31:0]              wbm_adr_i,
  input  logic [31:0]              wbm_dat_i,
  output logic [31:0]              wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [3:0]               wbs_sel_o,
  output logic [31:0]              wbs_adr_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [NUM_SLAVES*32-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic [31:0]           rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [31:0]           off;
  logic [31:0]           win;
  logic                  hit;
  logic [NUM_SLAVES-1:0] oh;
  logic                  s_ack;
  logic                  s_err;
  logic [31:0]           s_dat;

  always_comb begin
    off = wbm_adr_i - C_BASEADDR;
    win = off >> SLAVE_AW;
    // Below-base addresses wrap to huge offsets, but test explicitly anyway.
    hit = (wbm_adr_i >= C_BASEADDR) && (win < 32'(NUM_SLAVES));
    oh  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      oh[i] = (win == 32'(i));
    end
  end

  // cyc_q is one-hot while BUSY, so it doubles as the response selector.
  always_comb begin
    s_ack = |(wbs_ack_i & cyc_q);
    s_err = |(wbs_err_i & cyc_q);
    s_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cyc_q[i]) s_dat = s_dat | wbs_dat_i[32*i +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (!hit) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cyc_d   = oh;
            we_d    = wbm_we_i;
            sel_d   = wbm_sel_i;
            adr_d   = wbm_adr_i;
            dat_d   = wbm_dat_i;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (!wbm_cyc_i) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else if (s_err) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (s_ack) begin
          cyc_d   = '0;
          ack_d   = 1'b1;
          if (!we_q) rdat_d = s_dat;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Scoreboard bench for wb_slave_mux: directed scenarios then random traffic,
// responses checked by an independent monitor process.
module tb_wb_slave_mux;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [3:0]      m_sel = '0;
  logic [31:0]     m_adr = '0, m_dat = '0;
  logic [31:0]     r_dat;
  logic            r_ack, r_err;
  logic [NS-1:0]   s_cyc, s_stb;
  logic            s_we;
  logic [3:0]      s_sel;
  logic [31:0]     s_adr, s_wdat;
  logic [NS*32-1:0] sl_dat = '0;
  logic [NS-1:0]   sl_ack = '0, sl_err = '0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];
  logic [31:0] last_rd = '0;

  wb_slave_mux #(
    .C_BASEADDR(32'h0), .NUM_SLAVES(NS), .SLAVE_AW(AW), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we),
    .wbm_sel_i(m_sel), .wbm_adr_i(m_adr), .wbm_dat_i(m_dat),
    .wbm_dat_o(r_dat), .wbm_ack_o(r_ack), .wbm_err_o(r_err),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we),
    .wbs_sel_o(s_sel), .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat),
    .wbs_dat_i(sl_dat), .wbs_ack_i(sl_ack), .wbs_err_i(sl_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // Monitor: every master response is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (r_ack || r_err)) begin
      chk("ack_err_excl", {63'd0, r_ack & r_err}, 64'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp ack=%b err=%b req=none", r_ack, r_err);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {63'd0, r_err}, {63'd0, e.err});
        chk("resp_ack", {63'd0, r_ack}, {63'd0, ~e.err});
        chk("resp_dat", {32'd0, r_dat}, {32'd0, e.dat});
      end
    end
  end

  task automatic noise(input logic [NS-1:0] oh);
    sl_ack = NS'($urandom) & ~oh;
    sl_err = NS'($urandom) & ~oh;
    for (int k = 0; k < NS; k++) sl_dat[32*k +: 32] = $urandom;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 hang. j: stb cycle in which the slave
  // answers. drop_at>0: master drops cyc in that stb cycle (abort).
  task automatic txn(input logic [31:0] adr, input logic we,
                     input logic [31:0] wd, input logic [3:0] sel,
                     input int kind, input int j, input int drop_at,
                     input logic [31:0] rdata);
    int slot, n, exp_stb;
    bit mapped, done, is_err;
    logic [NS-1:0] oh;
    exp_t e;
    slot = int'(adr >> AW);
    mapped = slot < NS;
    oh = '0;
    if (mapped) oh[slot] = 1'b1;
    is_err = 1'b0;
    if (!mapped) begin
      is_err = 1'b1;
      exp_stb = 0;
    end else if (drop_at > 0) begin
      exp_stb = drop_at + 1;
    end else if (kind == 3 || j >= TO) begin
      is_err = 1'b1;
      exp_stb = TO;
    end else begin
      is_err = (kind != 0);
      exp_stb = j + 1;
    end
    if (!mapped || drop_at == 0) begin
      if (!is_err && !we) last_rd = rdata;
      e.err = is_err;
      e.dat = last_rd;
      sb.push_back(e);
    end
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
    m_adr = adr; m_dat = wd; m_sel = sel;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      noise(oh);
      if (r_ack || r_err) begin
        done = 1'b1;
      end else if (drop_at > 0 && n > drop_at) begin
        chk("abort_stb", {60'd0, s_stb}, 64'd0);
        done = 1'b1;
      end else if (s_stb != '0) begin
        if (n == 0) begin
          chk("stb_onehot", {60'd0, s_stb}, {60'd0, oh});
          chk("cyc_onehot", {60'd0, s_cyc}, {60'd0, oh});
          chk("fwd_we", {63'd0, s_we}, {63'd0, we});
          chk("fwd_sel", {60'd0, s_sel}, {60'd0, sel});
          chk("fwd_adr", {32'd0, s_adr}, {32'd0, adr});
          chk("fwd_dat", {32'd0, s_wdat}, {32'd0, wd});
        end
        if (drop_at > 0 && n == drop_at) begin
          m_cyc = 1'b0;
          m_stb = 1'b0;
        end
        if (n == j && kind != 3) begin
          if (kind != 1) sl_ack = sl_ack | oh;
          if (kind != 0) sl_err = sl_err | oh;
          sl_dat[32*slot +: 32] = rdata;
        end
        n++;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL txn_timeout adr=%h act=none req=response", adr);
    end
    chk("stb_cycles", 64'(n), 64'(exp_stb));
  endtask

  task automatic gap(input int g);
    m_cyc = 1'b0;
    m_stb = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int sl, k, j, d;
    logic [31:0] a;
    bit ok;
    @(negedge clk);
    chk("rst_stb", {60'd0, s_stb}, 64'd0);
    chk("rst_cyc", {60'd0, s_cyc}, 64'd0);
    chk("rst_ack", {63'd0, r_ack}, 64'd0);
    chk("rst_err", {63'd0, r_err}, 64'd0);
    chk("rst_dat", {32'd0, r_dat}, 64'd0);
    chk("rst_adr", {32'd0, s_adr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    txn(32'h0000_0000, 1'b1, 32'hEEEE_EEEE, 4'h4, 0, 1, 0, 32'h0);
    txn(32'h0002_0004, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'hDEAD_BEEF);
    gap(1);
    txn(32'h0005_0000, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h0);
    gap(2);
    txn(32'h0001_0000, 1'b0, 32'h0, 4'hF, 3, 0, 0, 32'h0);
    gap(1);
    txn(32'h0003_0000, 1'b0, 32'h0, 4'hF, 2, 2, 0, 32'h1234_5678);
    txn(32'h0003_0008, 1'b0, 32'h0, 4'h3, 0, 7, 0, 32'hCAFE_F00D);
    txn(32'h0003_000C, 1'b0, 32'h0, 4'h3, 0, 8, 0, 32'h0BAD_0BAD);
    gap(1);
    txn(32'h0001_0000, 1'b0, 32'h0, 4'hF, 0, 3, 2, 32'h5555_5555);
    gap(2);
    txn(32'h0002_0000, 1'b1, 32'h1111_2222, 4'hF, 0, 2, 2, 32'h0);
    gap(2);
    txn(32'h0001_0010, 1'b0, 32'h0, 4'hF, 0, 1, 0, 32'hA5A5_5A5A);
    gap(1);

    // Asynchronous reset while a slave is strobed.
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
    m_adr = 32'h0001_0000; m_sel = 4'hF;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (s_stb != '0) ok = (c >= 3);
    end
    chk("pre_rst_stb", {60'd0, s_stb}, 64'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_stb", {60'd0, s_stb}, 64'd0);
    chk("rst_mid_ack", {63'd0, r_ack}, 64'd0);
    chk("rst_mid_err", {63'd0, r_err}, 64'd0);
    chk("rst_mid_dat", {32'd0, r_dat}, 64'd0);
    last_rd = '0;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(32'h0000_0004, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h7777_0001);
    gap(1);

    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 19);
      sl = $urandom_range(0, 6);
      a = (sl == 6) ? 32'hABCD_0000 : (32'(sl) << AW);
      a = a | ((32'($urandom) & 32'h0000_FFFC));
      j = $urandom_range(0, 9);
      d = 0;
      if (k < 2 && sl < NS) begin
        d = $urandom_range(1, 3);
        if (j < d) j = d;
      end
      txn(a, 1'($urandom), $urandom, 4'($urandom),
          (k < 10) ? 0 : (k < 13) ? 1 : (k < 16) ? 2 : (k < 18) ? 3 : 0,
          j, d, $urandom);
      if ($urandom_range(0, 2) != 0) gap($urandom_range(1, 3));
    end
    gap(4);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
